// File: rtl/sdn_switch_pkg.sv
// Shared definitions for the SDN switch datapath: bus width defaults,
// input-arbiter FSM encoding, IOQ header ctrl value and the grant picker.
package sdn_switch_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CTRL_WIDTH = DEF_DATA_WIDTH / 8;
  localparam logic [7:0] IOQ_HDR_CTRL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PKT  = 2'd2
  } arb_state_e;

  // Returns {found, port}: strict scans from port 0, otherwise from last+1 wrapping at n.
  function automatic logic [3:0] arb_pick(input logic [7:0] nonempty,
                                          input logic [2:0] last,
                                          input int         n,
                                          input logic       strict);
    logic [3:0] res;
    int         cand;
    res  = 4'b0000;
    cand = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        cand = strict ? k : ((int'(last) + k + 1) % n);
        if (!res[3] && nonempty[cand[2:0]]) begin
          res = {1'b1, cand[2:0]};
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sdn_fallthrough_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout_o whenever
// the FIFO is non-empty; nearly_full_o means at most one free slot remains.
module sdn_fallthrough_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             nearly_full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  assign full_o        = (count_q == (DEPTH_BITS + 1)'(DEPTH));
  assign nearly_full_o = (count_q >= (DEPTH_BITS + 1)'(DEPTH - 1));
  assign empty_o       = (count_q == '0);
  assign wr_ok_s       = wr_en_i && !full_o;
  assign rd_ok_s       = rd_en_i && !empty_o;
  assign dout_o        = mem_q[rd_ptr_q];

  // Storage array, written only on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy; a simultaneous write and read leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_q <= count_q + (DEPTH_BITS + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_BITS + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdn_rr_input_arbiter.sv
// Merges NUM_QUEUES input streams into one, granting whole packets either
// round-robin or by strict priority (port 0 highest).
module sdn_rr_input_arbiter
  import sdn_switch_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CTRL_WIDTH      = DEF_CTRL_WIDTH,
  parameter int NUM_QUEUES      = 4,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int ARB_MODE        = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [2:0]                       cur_port,
  output logic [NUM_QUEUES-1:0]            ovf_err
);

  localparam int FW = DATA_WIDTH + CTRL_WIDTH;

  logic [NUM_QUEUES-1:0] full_s, nearly_full_s, empty_s, pop_s;
  logic [FW-1:0]         head_s [NUM_QUEUES];
  logic [FW-1:0]         sel_head_s;
  logic                  sel_empty_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [CTRL_WIDTH-1:0] sel_ctrl_s;
  logic [7:0]            nonempty_s;
  logic [3:0]            pick_s;
  logic                  pop_go_s;

  arb_state_e            state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0]            last_q, last_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [NUM_QUEUES-1:0] ovf_q, ovf_d;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fifo
    sdn_fallthrough_fifo #(
      .WIDTH      (FW),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .wr_en_i       (in_wr[i]),
      .din_i         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .rd_en_i       (pop_s[i]),
      .dout_o        (head_s[i]),
      .full_o        (full_s[i]),
      .nearly_full_o (nearly_full_s[i]),
      .empty_o       (empty_s[i])
    );
  end

  assign in_rdy     = ~nearly_full_s;
  assign sel_data_s = sel_head_s[DATA_WIDTH-1:0];
  assign sel_ctrl_s = sel_head_s[FW-1 -: CTRL_WIDTH];
  assign pick_s     = arb_pick(nonempty_s, last_q, NUM_QUEUES, ARB_MODE == 1);
  assign ovf_d      = ovf_q | (in_wr & full_s);

  // Head word/empty flag of the granted port and the per-port pop strobes.
  always_comb begin
    sel_head_s  = '0;
    sel_empty_s = 1'b1;
    nonempty_s  = 8'h00;
    nonempty_s[NUM_QUEUES-1:0] = ~empty_s;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      sel_head_s  = (grant_q == 3'(i)) ? head_s[i]  : sel_head_s;
      sel_empty_s = (grant_q == 3'(i)) ? empty_s[i] : sel_empty_s;
      pop_s[i]    = pop_go_s && (grant_q == 3'(i));
    end
  end

  // Packet FSM: grant in IDLE, stream the granted FIFO until the EOP word leaves.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pop_go_s   = 1'b0;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[3]) begin
          state_d = ST_HDR;
          grant_d = pick_s[2:0];
          last_d  = pick_s[2:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR, ST_PKT: begin
        if (out_rdy && !sel_empty_s) begin
          pop_go_s   = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = sel_data_s;
          out_ctrl_d = sel_ctrl_s;
          if (state_q == ST_HDR && sel_ctrl_s == '0) begin
            state_d = ST_PKT;
          end else if (state_q == ST_PKT && sel_ctrl_s != '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'd0;
      last_q     <= 3'(NUM_QUEUES - 1);
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign cur_port = grant_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_sdn_rr_input_arbiter.sv
// Scoreboard bench for sdn_rr_input_arbiter: a round-robin instance and a
// strict-priority instance, each with its own expected-word queue and monitor.
module tb_sdn_rr_input_arbiter;
  import sdn_switch_pkg::*;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [2:0]  p;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] in_data = '0, sp_in_data = '0;
  logic [31:0]  in_ctrl = '0, sp_in_ctrl = '0;
  logic [3:0]   in_wr = '0, sp_in_wr = '0;
  logic [3:0]   in_rdy, sp_in_rdy;
  logic [63:0]  out_data, sp_out_data;
  logic [7:0]   out_ctrl, sp_out_ctrl;
  logic         out_wr, sp_out_wr;
  logic         out_rdy = 1'b1, sp_out_rdy = 1'b1;
  logic [2:0]   cur_port, sp_cur_port;
  logic [3:0]   ovf_err, sp_ovf_err;

  exp_t sb_q[$];
  exp_t sp_q[$];
  exp_t e_rr, e_sp;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sdn_rr_input_arbiter #(.ARB_MODE(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .cur_port(cur_port), .ovf_err(ovf_err)
  );

  sdn_rr_input_arbiter #(.ARB_MODE(1)) dut_sp (
    .clk(clk), .reset(reset), .in_data(sp_in_data), .in_ctrl(sp_in_ctrl), .in_wr(sp_in_wr),
    .in_rdy(sp_in_rdy), .out_data(sp_out_data), .out_ctrl(sp_out_ctrl), .out_wr(sp_out_wr),
    .out_rdy(sp_out_rdy), .cur_port(sp_cur_port), .ovf_err(sp_ovf_err)
  );

  function automatic logic [63:0] mk_data(input int p, input int pkt, input int w);
    return 64'hD000_0000_0000_0000 | (64'(p) << 32) | (64'(pkt) << 16) | 64'(w);
  endfunction

  function automatic logic [7:0] ctrl_of(input int w, input int len);
    if (w == 0) return IOQ_HDR_CTRL;
    else if (w == len - 1) return 8'h04;
    else return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input bit sel, input int p, input int pkt, input int len, input int nwords);
    exp_t e;
    for (int w = 0; w < nwords; w++) begin
      e.d = mk_data(p, pkt, w);
      e.c = ctrl_of(w, len);
      e.p = 3'(p);
      if (sel) sp_q.push_back(e);
      else sb_q.push_back(e);
    end
  endtask

  task automatic send_pkt(input bit sel, input int p, input int pkt, input int len);
    for (int w = 0; w < len; w++) begin
      @(negedge clk);
      if (sel) begin
        sp_in_wr[p] = 1'b1;
        sp_in_data[p*64 +: 64] = mk_data(p, pkt, w);
        sp_in_ctrl[p*8 +: 8] = ctrl_of(w, len);
      end else begin
        in_wr[p] = 1'b1;
        in_data[p*64 +: 64] = mk_data(p, pkt, w);
        in_ctrl[p*8 +: 8] = ctrl_of(w, len);
      end
    end
    @(negedge clk);
    if (sel) sp_in_wr[p] = 1'b0;
    else in_wr[p] = 1'b0;
  endtask

  task automatic drain(input bit sel, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if ((sel ? sp_q.size() : sb_q.size()) == 0) break;
    end
    repeat (4) @(posedge clk);
    chk(name, 64'(sel ? sp_q.size() : sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_wr = '0;
    sp_in_wr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Round-robin instance monitor: every output word must match the queue head.
  always @(negedge clk) begin
    if (out_wr) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rr_unexpected_word: got data=%0h ctrl=%0h port=%0d, required no output",
                 out_data, out_ctrl, cur_port);
      end else begin
        e_rr = sb_q.pop_front();
        if (out_data !== e_rr.d || out_ctrl !== e_rr.c || cur_port !== e_rr.p) begin
          n_fail++;
          $display("FAIL rr_word: got data=%0h ctrl=%0h port=%0d, required data=%0h ctrl=%0h port=%0d",
                   out_data, out_ctrl, cur_port, e_rr.d, e_rr.c, e_rr.p);
        end
      end
    end
  end

  // Strict-priority instance monitor.
  always @(negedge clk) begin
    if (sp_out_wr) begin
      n_checks++;
      if (sp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sp_unexpected_word: got data=%0h ctrl=%0h port=%0d, required no output",
                 sp_out_data, sp_out_ctrl, sp_cur_port);
      end else begin
        e_sp = sp_q.pop_front();
        if (sp_out_data !== e_sp.d || sp_out_ctrl !== e_sp.c || sp_cur_port !== e_sp.p) begin
          n_fail++;
          $display("FAIL sp_word: got data=%0h ctrl=%0h port=%0d, required data=%0h ctrl=%0h port=%0d",
                   sp_out_data, sp_out_ctrl, sp_cur_port, e_sp.d, e_sp.c, e_sp.p);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] trace;
    int          first;
    int          bad;
    int          cnt;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_cur_port", 64'(cur_port), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'hF);

    // Single 4-word packet on port 2: first word at t+3, contiguous
    push_pkt(0, 2, 1, 4, 4);
    @(negedge clk);
    fork
      send_pkt(0, 2, 1, 4);
      begin
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lat_t2_out_wr", 64'(out_wr), 64'd0);
        chk("lat_grant_port2", 64'(cur_port), 64'd2);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("lat_stream_out_wr", 64'(out_wr), 64'd1);
        end
      end
    join
    drain(0, 50, "pkt34_drain");

    // Four ports loaded together: order 0..3, one idle cycle between packets
    do_reset();
    for (int p = 0; p < 4; p++) push_pkt(0, p, 2 + p, 5, 5);
    @(negedge clk);
    trace = '0;
    fork
      send_pkt(0, 0, 2, 5);
      send_pkt(0, 1, 3, 5);
      send_pkt(0, 2, 4, 5);
      send_pkt(0, 3, 5, 5);
      begin
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          trace[j] = out_wr;
        end
      end
    join
    first = -1;
    for (int j = 39; j >= 0; j--) if (trace[j]) first = j;
    bad = (first < 0 || first > 17) ? 1 : 0;
    for (int j = 0; j < 23; j++) begin
      if (bad == 0 && trace[first + j] != ((j % 6) != 5)) bad++;
    end
    chk("rr_stream_shape", 64'(bad), 64'd0);
    drain(0, 100, "rr4_drain");

    // out_rdy 1,0,0,1 during a 6-word packet on port 3
    out_rdy = 1'b0;
    push_pkt(0, 3, 8, 6, 6);
    send_pkt(0, 3, 8, 6);
    chk("in_rdy_six_words", 64'(in_rdy), 64'hF);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_first_word", 64'(out_wr), 64'd1);
    out_rdy = 1'b0;
    @(negedge clk);
    chk("bp_stall1", 64'(out_wr), 64'd0);
    @(negedge clk);
    chk("bp_stall2", 64'(out_wr), 64'd0);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_resume", 64'(out_wr), 64'd1);
    drain(0, 50, "bp_drain");

    // Overflow: 9 writes to port 1 with out_rdy low, 9th dropped
    out_rdy = 1'b0;
    push_pkt(0, 1, 9, 9, 8);
    send_pkt(0, 1, 9, 9);
    chk("ovf_set", 64'(ovf_err), 64'h2);
    chk("ovf_in_rdy", 64'(in_rdy), 64'hD);
    out_rdy = 1'b1;
    drain(0, 50, "ovf_drain");
    chk("ovf_sticky", 64'(ovf_err), 64'h2);

    // Reset after 2 words of a 6-word packet
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", 64'(ovf_err), 64'd0);
    chk("in_rdy_after_rst", 64'(in_rdy), 64'hF);
    out_rdy = 1'b0;
    push_pkt(0, 2, 6, 6, 2);
    send_pkt(0, 2, 6, 6);
    out_rdy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if (out_wr) cnt++;
    end
    reset = 1'b1;
    chk("mid_words_before_rst", 64'(cnt), 64'd2);
    @(negedge clk);
    chk("mid_rst_out_wr", 64'(out_wr), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_cur_port", 64'(cur_port), 64'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_wr) cnt++;
    end
    chk("mid_rst_fifos_empty", 64'(cnt), 64'd0);
    chk("mid_rst_queue", 64'(sb_q.size()), 64'd0);
    push_pkt(0, 0, 7, 4, 4);
    send_pkt(0, 0, 7, 4);
    drain(0, 50, "post_rst_drain");

    // Strict priority: port 0 refilled, ports 1..3 only once port 0 is empty
    sp_out_rdy = 1'b0;
    push_pkt(1, 0, 10, 5, 5);
    push_pkt(1, 0, 11, 5, 5);
    push_pkt(1, 1, 12, 5, 5);
    push_pkt(1, 2, 13, 5, 5);
    push_pkt(1, 3, 14, 5, 5);
    fork
      send_pkt(1, 0, 10, 5);
      send_pkt(1, 1, 12, 5);
      send_pkt(1, 2, 13, 5);
      send_pkt(1, 3, 14, 5);
    join
    sp_out_rdy = 1'b1;
    send_pkt(1, 0, 11, 5);
    drain(1, 150, "sp_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
